// File: rtl/rtype_issue_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : rtype_issue_ctrl_if
// Description : Bundle of the instruction handshake, register-file read/write
//               and ALU signals between rtype_issue_ctrl and its environment.
//               master : controller side (drives in_ready, addresses,
//                        operands, enables and the write-back bus)
//               slave  : environment side (fetch source, register file, ALU)
// Revision    : 1.0 - initial release
// ============================================================================
interface rtype_issue_ctrl_if #(
    parameter int XLEN = 32,
    parameter int RA_W = 5
);
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_instr;
    logic [RA_W-1:0] rs1_addr;
    logic [RA_W-1:0] rs2_addr;
    logic [XLEN-1:0] rf_rd1;
    logic [XLEN-1:0] rf_rd2;
    logic [XLEN-1:0] alu_a;
    logic [XLEN-1:0] alu_b;
    logic [9:0]      alu_en;
    logic [XLEN-1:0] alu_result;
    logic            wr_en;
    logic [RA_W-1:0] wr_addr;
    logic [XLEN-1:0] wr_data;
    logic            done;
    logic            illegal;

    modport master (
        input  in_valid, in_instr, rf_rd1, rf_rd2, alu_result,
        output in_ready, rs1_addr, rs2_addr, alu_a, alu_b, alu_en,
               wr_en, wr_addr, wr_data, done, illegal
    );

    modport slave (
        output in_valid, in_instr, rf_rd1, rf_rd2, alu_result,
        input  in_ready, rs1_addr, rs2_addr, alu_a, alu_b, alu_en,
               wr_en, wr_addr, wr_data, done, illegal
    );
endinterface
`default_nettype wire

// File: rtl/rtype_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : rtype_issue_ctrl
// Description : Sequencing controller for the RV32I R-type ALU. Accepts one
//               instruction per valid/ready handshake, decodes it into a
//               one-hot ALU enable, presents register-file operands, captures
//               the ALU result and issues one register-file write.
//               Sequence: IDLE -> DECODE -> EXEC -> WB -> IDLE (4 cycles),
//               or IDLE -> DECODE -> ERR -> IDLE for rejected instructions.
// Ports       : clk, rst      - clock (rising edge), async active-high reset
//               bus (master)  - handshake, rf read/write, ALU signals
//               retire_cnt    - retired instruction count (optional)
//               illegal_cnt   - rejected instruction count (optional)
// Config      : define RTYPE_RETIRE_CNT_EN to add retire_cnt/illegal_cnt
// Revision    : 1.0 - initial release
// ============================================================================
module rtype_issue_ctrl #(
    parameter int XLEN = 32,
    parameter int RA_W = 5
) (
    input  logic                clk,
    input  logic                rst,
`ifdef RTYPE_RETIRE_CNT_EN
    output logic [31:0]         retire_cnt,
    output logic [15:0]         illegal_cnt,
`endif
    rtype_issue_ctrl_if.master  bus
);

    localparam logic [6:0] OPC_OP   = 7'b0110011;
    localparam logic [6:0] F7_BASE  = 7'b0000000;
    localparam logic [6:0] F7_ALT   = 7'b0100000;

    // One-hot enable order {add,sub,or,xor,and,slt,sltu,sll,srl,sra}, MSB = add
    localparam logic [9:0] EN_ADD   = 10'b1000000000;
    localparam logic [9:0] EN_SUB   = 10'b0100000000;
    localparam logic [9:0] EN_OR    = 10'b0010000000;
    localparam logic [9:0] EN_XOR   = 10'b0001000000;
    localparam logic [9:0] EN_AND   = 10'b0000100000;
    localparam logic [9:0] EN_SLT   = 10'b0000010000;
    localparam logic [9:0] EN_SLTU  = 10'b0000001000;
    localparam logic [9:0] EN_SLL   = 10'b0000000100;
    localparam logic [9:0] EN_SRL   = 10'b0000000010;
    localparam logic [9:0] EN_SRA   = 10'b0000000001;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_WB     = 3'd3,
        ST_ERR    = 3'd4
    } state_t;

    state_t          state_q;
    logic [XLEN-1:0] instr_q;
    logic            in_ready_q;
    logic [XLEN-1:0] alu_a_q;
    logic [XLEN-1:0] alu_b_q;
    logic [9:0]      alu_en_q;
    logic            wr_en_q;
    logic [RA_W-1:0] wr_addr_q;
    logic [XLEN-1:0] wr_data_q;
    logic            done_q;
    logic            illegal_q;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [RA_W-1:0] rd;
    logic [9:0]      alu_en_d;
    logic            is_shift;
    logic            legal;
    logic [XLEN-1:0] alu_b_d;

    assign opcode = instr_q[6:0];
    assign funct3 = instr_q[14:12];
    assign funct7 = instr_q[31:25];
    assign rd     = instr_q[11:7];

    // Read addresses come straight from the latched instruction, so they are
    // stable from DECODE through EXEC and hold until the next accept.
    assign bus.rs1_addr = instr_q[19:15];
    assign bus.rs2_addr = instr_q[24:20];

    always_comb begin
        alu_en_d = '0;
        is_shift = 1'b0;
        if (opcode == OPC_OP) begin
            if (funct7 == F7_BASE) begin
                case (funct3)
                    3'b000: alu_en_d = EN_ADD;
                    3'b001: begin alu_en_d = EN_SLL; is_shift = 1'b1; end
                    3'b010: alu_en_d = EN_SLT;
                    3'b011: alu_en_d = EN_SLTU;
                    3'b100: alu_en_d = EN_XOR;
                    3'b101: begin alu_en_d = EN_SRL; is_shift = 1'b1; end
                    3'b110: alu_en_d = EN_OR;
                    default: alu_en_d = EN_AND;
                endcase
            end else if (funct7 == F7_ALT) begin
                case (funct3)
                    3'b000: alu_en_d = EN_SUB;
                    3'b101: begin alu_en_d = EN_SRA; is_shift = 1'b1; end
                    default: alu_en_d = '0;
                endcase
            end
        end
        // Any legal encoding maps to exactly one enable bit.
        legal = |alu_en_d;
    end

    // Shifts only ever use the low five bits of rs2 as the shift amount.
    assign alu_b_d = is_shift ? {{(XLEN-5){1'b0}}, bus.rf_rd2[4:0]} : bus.rf_rd2;

`ifdef RTYPE_RETIRE_CNT_EN
    logic [31:0] retire_cnt_q;
    logic [15:0] illegal_cnt_q;
    assign retire_cnt  = retire_cnt_q;
    assign illegal_cnt = illegal_cnt_q;
`else
    // Retire/illegal counters are not built in this configuration.
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            instr_q    <= '0;
            in_ready_q <= 1'b1;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_en_q   <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            done_q     <= 1'b0;
            illegal_q  <= 1'b0;
`ifdef RTYPE_RETIRE_CNT_EN
            retire_cnt_q  <= '0;
            illegal_cnt_q <= '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.in_valid && in_ready_q) begin
                        instr_q    <= bus.in_instr;
                        in_ready_q <= 1'b0;
                        state_q    <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    if (legal) begin
                        alu_a_q  <= bus.rf_rd1;
                        alu_b_q  <= alu_b_d;
                        alu_en_q <= alu_en_d;
                        state_q  <= ST_EXEC;
                    end else begin
                        illegal_q <= 1'b1;
                        state_q   <= ST_ERR;
`ifdef RTYPE_RETIRE_CNT_EN
                        illegal_cnt_q <= illegal_cnt_q + 16'd1;
`endif
                    end
                end
                ST_EXEC: begin
                    alu_en_q  <= '0;
                    wr_data_q <= bus.alu_result;
                    wr_addr_q <= rd;
                    // x0 is hard-wired: retire without writing.
                    wr_en_q   <= (rd != '0);
                    done_q    <= 1'b1;
                    state_q   <= ST_WB;
`ifdef RTYPE_RETIRE_CNT_EN
                    retire_cnt_q <= retire_cnt_q + 32'd1;
`endif
                end
                ST_WB: begin
                    wr_en_q    <= 1'b0;
                    done_q     <= 1'b0;
                    in_ready_q <= 1'b1;
                    state_q    <= ST_IDLE;
                end
                ST_ERR: begin
                    illegal_q  <= 1'b0;
                    in_ready_q <= 1'b1;
                    state_q    <= ST_IDLE;
                end
                default: begin
                    alu_en_q   <= '0;
                    wr_en_q    <= 1'b0;
                    done_q     <= 1'b0;
                    illegal_q  <= 1'b0;
                    in_ready_q <= 1'b1;
                    state_q    <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready = in_ready_q;
    assign bus.alu_a    = alu_a_q;
    assign bus.alu_b    = alu_b_q;
    assign bus.alu_en   = alu_en_q;
    assign bus.wr_en    = wr_en_q;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.wr_data  = wr_data_q;
    assign bus.done     = done_q;
    assign bus.illegal  = illegal_q;

endmodule
`default_nettype wire
